// File: rtl/fft_pkg.sv
// Shared constants, state encoding and bit-reverse helper for the fft_sched scheduler.
package fft_pkg;

  localparam int unsigned N      = 32;
  localparam int unsigned LOG2N  = 5;
  localparam int unsigned NSTAGE = 5;
  localparam int unsigned LAT    = 36;

  // Per-stage tick offset of the local position, and butterfly delay-line length.
  localparam logic [NSTAGE-1:0][5:0] OFS = {6'd34, 6'd31, 6'd26, 6'd17, 6'd0};
  localparam logic [NSTAGE-1:0][4:0] D   = {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

  // flush_cnt is loaded on sample N-1, so it reads N on the tick LAT after sample 0.
  localparam logic [5:0] FLUSH_RELOAD = 6'(LAT);
  localparam logic [5:0] FLUSH_OUT0   = 6'(N);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StFlush = 2'b10
  } state_e;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_pos.sv
// Local sample position and FIRST/SECOND phase bit of one butterfly stage, computed from
// the current tick position minus a fixed offset.
module fft_stage_pos
  import fft_pkg::*;
#(
  parameter int unsigned Ofs   = 0,
  parameter int unsigned Stage = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [LOG2N-1:0] i_pos,
  output logic [LOG2N-1:0] o_pos,
  output logic             o_mode
);

  localparam logic [LOG2N-1:0] OfsMod  = LOG2N'(Ofs % N);
  localparam int unsigned      ModeBit = LOG2N - 1 - Stage;

  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] r_pos;
  logic             r_mode;

  // Modulo-N subtraction: position lags the input counter by Ofs ticks.
  assign w_pos = i_pos - OfsMod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos  <= '0;
      r_mode <= 1'b0;
    end else if (i_en) begin
      r_pos  <= w_pos;
      r_mode <= w_pos[ModeBit];
    end
  end

  assign o_pos  = r_pos;
  assign o_mode = r_mode;

endmodule

// File: rtl/fft_sched.sv
// Tick/phase scheduler for a 32-point, five-stage pipelined FFT.
// Optional FFT_SCHED_FRAME_CNT_EN adds frame_cnt_o, a wrapping count of completed frames.
module fft_sched
  import fft_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_i,
  output logic                    en_o,
  output logic [NSTAGE-1:0]       mode_o,
  output logic [NSTAGE*LOG2N-1:0] stg_cnt_o,
  output logic                    valid_o,
  output logic [LOG2N-1:0]        out_idx_o,
  output logic                    busy_o,
  output logic                    frame_done_o
`ifdef FFT_SCHED_FRAME_CNT_EN
  ,
  output logic [7:0]              frame_cnt_o
`endif
);

  state_e           r_state;
  logic [LOG2N-1:0] r_cnt;
  logic [5:0]       r_flush;
  logic             r_out_act;
  logic [LOG2N-1:0] r_out_cnt;

  logic             w_en;
  logic             w_sample;
  logic             w_start;
  logic             w_last;
  logic [LOG2N-1:0] w_cur;
  logic             w_out_first;
  logic             w_valid;
  logic [LOG2N-1:0] w_out_pos;

  assign w_en     = rst_n & ((r_state == StFlush) | valid_i);
  assign w_sample = w_en & valid_i;
  // Any accepted sample outside RUN opens a new frame at position 0.
  assign w_start  = w_sample & (r_state != StRun);
  assign w_cur    = w_start ? '0 : r_cnt;
  assign w_last   = w_sample & (w_cur == LOG2N'(N - 1));

  assign w_out_first = w_en & (r_flush == FLUSH_OUT0);
  assign w_valid     = w_out_first | (w_en & r_out_act);
  assign w_out_pos   = w_out_first ? '0 : r_out_cnt;

  // The frame boundary hands over to FLUSH at once; FLUSH ticks on every cycle and a
  // sample arriving there starts the next frame, so no tick is lost between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_flush   <= '0;
      r_out_act <= 1'b0;
      r_out_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle:  if (w_sample) r_state <= StRun;
        StRun:   if (w_last) r_state <= StFlush;
        StFlush: begin
          if (w_sample) begin
            r_state <= StRun;
          end else if (r_flush <= 6'd1) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase

      if (w_en) begin
        r_cnt <= w_cur + 5'd1;
      end

      if (w_last) begin
        r_flush <= FLUSH_RELOAD;
      end else if (w_en && (r_flush != 6'd0)) begin
        r_flush <= r_flush - 6'd1;
      end

      if (w_valid) begin
        r_out_cnt <= w_out_pos + 5'd1;
        r_out_act <= (w_out_pos != LOG2N'(N - 1));
      end
    end
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    fft_stage_pos #(
      .Ofs   (int'(OFS[k])),
      .Stage (k)
    ) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_en),
      .i_pos  (w_cur),
      .o_pos  (stg_cnt_o[LOG2N*k +: LOG2N]),
      .o_mode (mode_o[k])
    );
  end

  assign en_o         = w_en;
  assign valid_o      = w_valid;
  assign out_idx_o    = w_valid ? bit_rev(w_out_pos) : '0;
  assign frame_done_o = w_valid & (w_out_pos == LOG2N'(N - 1));
  assign busy_o       = (r_state != StIdle);

`ifdef FFT_SCHED_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (frame_done_o) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt_o = r_frame_cnt;
`endif

endmodule

// File: tb/tb_fft_sched.sv
// Self-checking bench for fft_sched: a tick-level reference model pushes expected outputs
// into a scoreboard queue as samples are driven; DUT outputs are popped and compared.
module tb_fft_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic        en_o;
  logic [4:0]  mode_o;
  logic [24:0] stg_cnt_o;
  logic        valid_o;
  logic [4:0]  out_idx_o;
  logic        busy_o;
  logic        frame_done_o;
`ifdef FFT_SCHED_FRAME_CNT_EN
  logic [7:0]  frame_cnt_o;
`endif

  fft_sched u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_i      (valid_i),
    .en_o         (en_o),
    .mode_o       (mode_o),
    .stg_cnt_o    (stg_cnt_o),
    .valid_o      (valid_o),
    .out_idx_o    (out_idx_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
`ifdef FFT_SCHED_FRAME_CNT_EN
    ,
    .frame_cnt_o  (frame_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tick;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  exp_t        sb[$];
  int          ofs_tb[5] = '{0, 17, 26, 31, 34};
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned m_tick;
  int          m_cnt;
  int          m_flush;
  int          m_tp;
  int          m_frames;
  logic [4:0]  m_stg[5];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (tick %0d)", tag, got, exp, m_tick);
    end
  endtask

  function automatic logic [4:0] rev5(input int p);
    logic [4:0] v;
    logic [4:0] r;
    v = p[4:0];
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_tick   = 0;
    m_cnt    = 0;
    m_flush  = 0;
    m_tp     = 0;
    m_frames = 0;
    for (int k = 0; k < 5; k++) m_stg[k] = '0;
  endtask

  // One clock cycle: drive valid_i, check outputs at the falling edge, advance the model.
  task automatic step(input logic v);
    logic        en_x;
    logic        busy_x;
    logic        vld_x;
    logic [24:0] stg_x;
    logic [4:0]  mode_x;
    exp_t        e;
    int          cur;
    valid_i = v;
    @(negedge clk);
    en_x   = (m_cnt == 0 && m_flush != 0) ? 1'b1 : v;
    busy_x = (m_cnt != 0 || m_flush != 0);
    for (int k = 0; k < 5; k++) begin
      stg_x[5*k +: 5] = m_stg[k];
      mode_x[k]       = m_stg[k][4-k];
    end
    check_eq("en_o", en_o, en_x);
    check_eq("busy_o", busy_o, busy_x);
    check_eq("stg_cnt_o", stg_cnt_o, stg_x);
    check_eq("mode_o", mode_o, mode_x);
`ifdef FFT_SCHED_FRAME_CNT_EN
    check_eq("frame_cnt_o", frame_cnt_o, 8'(m_frames));
`endif
    vld_x = en_x && (sb.size() != 0) && (sb[0].tick == m_tick);
    check_eq("valid_o", valid_o, vld_x);
    if (vld_x) begin
      e = sb.pop_front();
      check_eq("out_idx_o", out_idx_o, e.idx);
      check_eq("frame_done_o", frame_done_o, e.last);
      if (e.last) m_frames++;
    end else begin
      check_eq("idle out_idx/frame_done", {out_idx_o, frame_done_o}, 6'd0);
    end
    if (en_x) begin
      cur = (v && m_cnt == 0) ? 0 : m_tp;
      if (v && m_cnt == 0) begin
        for (int p = 0; p < 32; p++) begin
          sb.push_back('{tick: m_tick + 36 + p, idx: rev5(p), last: (p == 31)});
        end
      end
      for (int k = 0; k < 5; k++) m_stg[k] = 5'(cur - ofs_tb[k]);
      m_tp = (cur + 1) % 32;
      if (v) begin
        if (m_cnt == 31) begin
          m_cnt   = 0;
          m_flush = 36;
        end else begin
          m_cnt++;
          if (m_flush != 0) m_flush--;
        end
      end else if (m_flush != 0) begin
        m_flush--;
      end
      m_tick++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    valid_i = 1'b1;
    #1;
    check_eq("reset outputs", {en_o, mode_o, valid_o, out_idx_o, busy_o, frame_done_o}, 14'd0);
    check_eq("reset stg_cnt_o", stg_cnt_o, 25'd0);
    model_reset();
    @(negedge clk);
    check_eq("reset outputs held", {en_o, mode_o, valid_o, out_idx_o, busy_o, frame_done_o},
             14'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    valid_i = 1'b0;
  endtask

  // Frame, then a gap until the drain counter reaches 'at', then a new frame in FLUSH.
  task automatic restart(input int at);
    repeat (32) step(1'b1);
    for (int i = 0; i < 64 && m_flush != at; i++) step(1'b0);
    check_eq("busy while flushing", busy_o, 1'b1);
    repeat (32) step(1'b1);
    repeat (45) step(1'b0);
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    model_reset();
    #2;
    do_reset();
    repeat (3) step(1'b0);

    repeat (32) step(1'b1);
    repeat (40) step(1'b0);
    check_eq("idle after single frame", busy_o, 1'b0);

    repeat (96) step(1'b1);
    repeat (40) step(1'b0);

    repeat (11) step(1'b1);
    repeat (5) step(1'b0);
    repeat (21) step(1'b1);
    repeat (45) step(1'b0);

    restart(10);
    restart(1);

    repeat (32) step(1'b1);
    for (int i = 0; i < 100 && sb.size() > 12; i++) step(1'b0);
    do_reset();
    repeat (40) step(1'b0);
    check_eq("no output after reset", busy_o, 1'b0);

    repeat (400) step($urandom_range(0, 3) != 0);
    for (int i = 0; i < 32 && m_cnt != 0; i++) step(1'b1);
    repeat (80) step(1'b0);

`ifdef FFT_SCHED_FRAME_CNT_EN
    do_reset();
    repeat (257 * 32) step(1'b1);
    repeat (45) step(1'b0);
    check_eq("frame_cnt_o after 257 frames", frame_cnt_o, 8'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
